// File: rtl/bch_pkg.sv
// Shared types, default parameters and the unrolled LFSR step for the
// streaming BCH encoder.
package bch_pkg;

    // Default code geometry.
    localparam int BCH_K = 64;
    localparam int BCH_W = 16;
    localparam int BCH_P = 14;
    localparam logic [BCH_P-1:0] BCH_GEN_POLY = 14'h0001;

    // Derived beat counts for the default geometry.
    localparam int BCH_D_BEATS = BCH_K / BCH_W;
    localparam int BCH_P_BEATS = (BCH_P + BCH_W - 1) / BCH_W;

    // Widest remainder / beat the step function is built to handle.
    localparam int BCH_MAX_P = 64;
    localparam int BCH_MAX_W = 256;

    typedef enum logic [0:0] {
        ST_DATA   = 1'b0,
        ST_PARITY = 1'b1
    } bch_state_e;

    // Advance the remainder by w message bits, MSB of din[w-1:0] first.
    // p, w and poly are elaboration constants at every call site, so the
    // loop unrolls into a pure XOR network.
    function automatic logic [BCH_MAX_P-1:0] bch_lfsr_step(
        input logic [BCH_MAX_P-1:0] rem,
        input logic [BCH_MAX_W-1:0] din,
        input int                   p,
        input int                   w,
        input logic [BCH_MAX_P-1:0] poly
    );
        logic [BCH_MAX_P-1:0] r;
        logic [BCH_MAX_P-1:0] mask;
        logic                 fb;
        r    = rem;
        mask = '0;
        fb   = 1'b0;
        for (int i = 0; i < BCH_MAX_P; i++) begin
            if (i < p) begin
                mask[i] = 1'b1;
            end else begin
                mask[i] = 1'b0;
            end
        end
        for (int i = 0; i < BCH_MAX_W; i++) begin
            if (i < w) begin
                fb = r[p-1] ^ din[w-1-i];
                r  = ((r << 1) & mask) ^ (fb ? (poly & mask) : '0);
            end else begin
                r  = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bch_rem_reg.sv
// P-bit remainder register of the encoder LFSR; clear has priority over load.
module bch_rem_reg #(
    parameter int P = 14
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [P-1:0] rem_d_i,
    output logic [P-1:0] rem_o
);

    logic [P-1:0] rem_q;

    // Remainder state: async reset, sync clear, otherwise load or hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem_q <= '0;
        end else if (clr_i) begin
            rem_q <= '0;
        end else if (load_i) begin
            rem_q <= rem_d_i;
        end else begin
            rem_q <= rem_q;
        end
    end

    assign rem_o = rem_q;

endmodule

// File: rtl/bch_stream_enc.sv
// Streaming systematic BCH encoder: echoes K/W message beats, then emits
// ceil(P/W) left-aligned parity beats through a single registered output slot.
module bch_stream_enc
    import bch_pkg::*;
#(
    parameter int           K        = BCH_K,
    parameter int           W        = BCH_W,
    parameter int           P        = BCH_P,
    parameter logic [P-1:0] GEN_POLY = BCH_GEN_POLY
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_data,
    output logic         m_parity,
    output logic         m_last
);

    localparam int D_BEATS = K / W;
    localparam int P_BEATS = (P + W - 1) / W;
    localparam int T_BEATS = D_BEATS + P_BEATS;
    localparam int BCNT_W  = $clog2(T_BEATS);
    localparam int PAD_W   = P_BEATS * W;

    // Reject geometries the datapath cannot represent.
    if ((W < 1) || (W > K) || ((K % W) != 0) || (P < 1) ||
        (P > BCH_MAX_P) || (W > BCH_MAX_W)) begin : g_bad_geometry
        $error("bch_stream_enc: unsupported K/W/P combination");
    end

    bch_state_e         state_q, state_d;
    logic [BCNT_W-1:0]  cnt_q, cnt_d;
    logic               m_valid_q, m_valid_d;
    logic [W-1:0]       m_data_q, m_data_d;
    logic               m_parity_q, m_parity_d;
    logic               m_last_q, m_last_d;

    logic [P-1:0]       rem_s;
    logic [P-1:0]       rem_step_s;
    logic               rem_clr_s;
    logic               rem_load_s;
    logic               slot_free_s;
    logic               s_ready_s;
    int                 par_idx_s;
    logic [PAD_W-1:0]   par_pad_s;
    logic [W-1:0]       par_beat_s;

    bch_rem_reg #(
        .P (P)
    ) u_rem (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (rem_clr_s),
        .load_i  (rem_load_s),
        .rem_d_i (rem_step_s),
        .rem_o   (rem_s)
    );

    // Remainder after absorbing the current input beat, and the parity beat
    // selected by the counter (remainder left-aligned, zero-filled LSBs).
    always_comb begin
        rem_step_s = P'(bch_lfsr_step(BCH_MAX_P'(rem_s), BCH_MAX_W'(s_data),
                                      P, W, BCH_MAX_P'(GEN_POLY)));
        par_idx_s  = int'(cnt_q) - D_BEATS;
        par_pad_s  = PAD_W'(rem_s) << (PAD_W - P);
        par_beat_s = W'(par_pad_s >> (W * (P_BEATS - 1 - par_idx_s)));
    end

    // Next-state, counter, output slot and remainder controls.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        m_valid_d   = m_valid_q;
        m_data_d    = m_data_q;
        m_parity_d  = m_parity_q;
        m_last_d    = m_last_q;
        rem_clr_s   = 1'b0;
        rem_load_s  = 1'b0;
        s_ready_s   = 1'b0;
        slot_free_s = !m_valid_q || m_ready;

        if (clr) begin
            // Abort: drop any pending beat and restart the codeword.
            state_d    = ST_DATA;
            cnt_d      = '0;
            m_valid_d  = 1'b0;
            m_parity_d = 1'b0;
            m_last_d   = 1'b0;
            rem_clr_s  = 1'b1;
        end else begin
            // A consumed beat leaves the slot empty unless refilled below.
            if (slot_free_s) begin
                m_valid_d = 1'b0;
            end else begin
                m_valid_d = m_valid_q;
            end
            case (state_q)
                ST_DATA: begin
                    s_ready_s = slot_free_s;
                    if (s_valid && slot_free_s) begin
                        m_valid_d  = 1'b1;
                        m_data_d   = s_data;
                        m_parity_d = 1'b0;
                        m_last_d   = 1'b0;
                        rem_load_s = 1'b1;
                        cnt_d      = cnt_q + BCNT_W'(1);
                        if (cnt_q == BCNT_W'(D_BEATS - 1)) begin
                            state_d = ST_PARITY;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_PARITY: begin
                    s_ready_s = 1'b0;
                    if (slot_free_s) begin
                        m_valid_d  = 1'b1;
                        m_data_d   = par_beat_s;
                        m_parity_d = 1'b1;
                        if (cnt_q == BCNT_W'(T_BEATS - 1)) begin
                            m_last_d  = 1'b1;
                            cnt_d     = '0;
                            rem_clr_s = 1'b1;
                            state_d   = ST_DATA;
                        end else begin
                            m_last_d  = 1'b0;
                            cnt_d     = cnt_q + BCNT_W'(1);
                            state_d   = ST_PARITY;
                        end
                    end else begin
                        state_d = ST_PARITY;
                    end
                end
                default: begin
                    state_d   = ST_DATA;
                    cnt_d     = '0;
                    m_valid_d = 1'b0;
                    rem_clr_s = 1'b1;
                end
            endcase
        end
    end

    // State, beat counter and registered output slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_DATA;
            cnt_q      <= '0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_parity_q <= 1'b0;
            m_last_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            m_parity_q <= m_parity_d;
            m_last_q   <= m_last_d;
        end
    end

    assign s_ready  = s_ready_s;
    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;
    assign m_parity = m_parity_q;
    assign m_last   = m_last_q;

endmodule

// File: tb/tb_bch_stream_enc.sv
// Scoreboard bench for bch_stream_enc: expected beats are queued on input
// acceptance (parity from a polynomial long-division model) and compared
// as the DUT hands them downstream.
module tb_bch_stream_enc;
    import bch_pkg::*;

    localparam int K  = BCH_K;
    localparam int W  = BCH_W;
    localparam int P  = BCH_P;
    localparam int DB = BCH_D_BEATS;
    localparam int PB = BCH_P_BEATS;
    localparam logic [P-1:0] GP = BCH_GEN_POLY;

    typedef struct packed {
        logic [W-1:0] data;
        logic         par;
        logic         last;
    } beat_t;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         clr = 1'b0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [W-1:0] s_data = '0;
    logic         m_valid;
    logic         m_ready = 1'b0;
    logic [W-1:0] m_data;
    logic         m_parity;
    logic         m_last;

    beat_t        exp_q[$];
    int           total = 0;
    int           bad = 0;
    int           stalls = 0;
    int           beats_out = 0;
    int           cyc = 0;
    logic         mon_en = 1'b0;
    logic         rnd_rdy = 1'b0;
    logic         rdy_fix = 1'b0;
    logic         stall_prev = 1'b0;
    beat_t        held = '0;
    logic [W-1:0] last_par = '0;

    bch_stream_enc #(.K(K), .W(W), .P(P), .GEN_POLY(GP)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (clr),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_parity (m_parity),
        .m_last   (m_last)
    );

    always #5 clk = ~clk;

    // Cycle counter for throughput measurement.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // Reference remainder: m(x)*x^P mod g(x) by long division.
    function automatic logic [P-1:0] golden_rem(input logic [K-1:0] msg);
        logic [K+P-1:0] v;
        v = {msg, {P{1'b0}}};
        for (int i = K + P - 1; i >= P; i--) begin
            if (v[i]) v[i -: P+1] = v[i -: P+1] ^ {1'b1, GP};
        end
        return v[P-1:0];
    endfunction

    // Downstream ready: random or fixed, changed shortly after each edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            m_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : rdy_fix;
        end
    end

    // Output monitor: pops the scoreboard and checks stall stability.
    always @(negedge clk) begin
        if (mon_en) begin
            if (stall_prev) begin
                check_val("stall_valid", 64'(m_valid), 64'd1);
                check_val("stall_hold", 64'({m_data, m_parity, m_last}), 64'(held));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_beat", 64'(exp_q.size()), 64'd1);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check_val("beat_data", 64'(m_data), 64'(e.data));
                    check_val("beat_par", 64'(m_parity), 64'(e.par));
                    check_val("beat_last", 64'(m_last), 64'(e.last));
                end
                if (m_parity) last_par <= m_data;
                beats_out <= beats_out + 1;
            end
            stall_prev <= m_valid && !m_ready;
            held       <= {m_data, m_parity, m_last};
        end else begin
            stall_prev <= 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat until accepted; returns just after the accepting edge.
    task automatic send_beat(input logic [W-1:0] d);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            stalls++;
            n++;
            if (n > 1000) begin
                check_val("accept_timeout", 64'(n), 64'd0);
                break;
            end
        end
        step();
        exp_q.push_back({d, 1'b0, 1'b0});
    endtask

    task automatic send_cw(input logic [K-1:0] msg, input bit gaps);
        logic [P-1:0]    r;
        logic [PB*W-1:0] pad;
        for (int b = 0; b < DB; b++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                s_valid = 1'b0;
                step();
            end
            send_beat(msg[K-1-b*W -: W]);
        end
        r   = golden_rem(msg);
        pad = (PB*W)'(r) << (PB*W - P);
        for (int j = 0; j < PB; j++) begin
            exp_q.push_back({pad[PB*W-1-j*W -: W], 1'b1, (j == PB - 1)});
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0) && (n < 500)) begin
            @(negedge clk);
            n++;
        end
        check_val("drain_empty", 64'(exp_q.size()), 64'd0);
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [K-1:0] msg;
        int           t0;
        int           b0;

        // Reset state.
        #3;
        check_val("rst_m_valid", 64'(m_valid), 64'd0);
        check_val("rst_m_data", 64'(m_data), 64'd0);
        check_val("rst_m_parity", 64'(m_parity), 64'd0);
        check_val("rst_m_last", 64'(m_last), 64'd0);
        #9;
        reset_n = 1'b1;
        step();
        @(negedge clk);
        check_val("rst_s_ready", 64'(s_ready), 64'd1);
        step();

        // 1: all-zero codeword.
        rdy_fix = 1'b1;
        mon_en  = 1'b1;
        b0 = beats_out;
        send_cw('0, 1'b0);
        s_valid = 1'b0;
        drain();
        check_val("zero_beats", 64'(beats_out - b0), 64'(DB + PB));

        // 2: unit message, echo one cycle after acceptance.
        for (int b = 0; b < DB; b++) begin
            logic [W-1:0] d;
            d = (b == DB - 1) ? W'(1) : W'(0);
            send_beat(d);
            s_valid = 1'b0;
            @(negedge clk);
            check_val("echo_valid", 64'(m_valid), 64'd1);
            check_val("echo_data", 64'(m_data), 64'(d));
            step();
        end
        begin
            logic [PB*W-1:0] pad;
            pad = (PB*W)'(golden_rem(K'(1))) << (PB*W - P);
            for (int j = 0; j < PB; j++) begin
                exp_q.push_back({pad[PB*W-1-j*W -: W], 1'b1, (j == PB - 1)});
            end
        end
        drain();
        check_val("unit_parity", 64'(last_par), 64'({GP, 2'b00}));

        // 3: random codewords under random backpressure and input gaps.
        rnd_rdy = 1'b1;
        for (int c = 0; c < 200; c++) begin
            msg = K'({$urandom, $urandom});
            send_cw(msg, 1'b1);
        end
        s_valid = 1'b0;
        rnd_rdy = 1'b0;
        rdy_fix = 1'b1;
        drain();

        // 4: back-to-back streaming at full rate.
        stalls = 0;
        t0 = cyc;
        for (int c = 0; c < 10; c++) begin
            msg = K'({$urandom, $urandom});
            send_cw(msg, 1'b0);
        end
        check_val("b2b_cycles", 64'(cyc - t0), 64'(10 * (DB + PB) - 1));
        check_val("b2b_stalls", 64'(stalls), 64'd9);
        s_valid = 1'b0;
        drain();

        // 5: clr after two beats, with a competing s_valid.
        send_beat(16'h1234);
        send_beat(16'hABCD);
        s_valid = 1'b1;
        s_data  = 16'h5555;
        clr     = 1'b1;
        @(negedge clk);
        check_val("clr_s_ready", 64'(s_ready), 64'd0);
        step();
        clr     = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        check_val("clr_m_valid", 64'(m_valid), 64'd0);
        step();
        msg = K'({$urandom, $urandom});
        send_cw(msg, 1'b0);
        s_valid = 1'b0;
        drain();

        // 6: reset pulse while stalled in the parity phase.
        msg = K'({$urandom, $urandom});
        send_cw(msg, 1'b0);
        s_valid = 1'b0;
        rdy_fix = 1'b0;
        @(negedge clk);
        step();
        @(negedge clk);
        check_val("par_s_ready", 64'(s_ready), 64'd0);
        check_val("par_m_valid", 64'(m_valid), 64'd1);
        mon_en = 1'b0;
        #1;
        reset_n = 1'b0;
        #1;
        check_val("arst_m_valid", 64'(m_valid), 64'd0);
        check_val("arst_m_data", 64'(m_data), 64'd0);
        check_val("arst_m_parity", 64'(m_parity), 64'd0);
        check_val("arst_m_last", 64'(m_last), 64'd0);
        exp_q.delete();
        #1;
        reset_n = 1'b1;
        step();
        rdy_fix = 1'b1;
        mon_en  = 1'b1;
        msg = K'({$urandom, $urandom});
        send_cw(msg, 1'b0);
        s_valid = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
